// File: rtl/qsfp_i2c_pkg.sv
// Shared types and constants for the QSFP I2C command arbiter.
package qsfp_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int I2C_ID_W   = 8;
    localparam int I2C_ADDR_W = 8;
    localparam int I2C_DATA_W = 8;

    localparam logic [I2C_DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;
    localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd3_000_000;

endpackage

// File: rtl/qsfp_i2c_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module qsfp_i2c_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qsfp_i2c_cmd_arbiter.sv
// Shares the single I2C sequencer command port between NUM_REQ requesters,
// round-robin, one transaction at a time, with a WAIT watchdog.
module qsfp_i2c_cmd_arbiter
    import qsfp_i2c_pkg::*;
#(
    parameter int                  NUM_REQ        = 2,
    parameter int                  TO_WIDTH       = 24,
    parameter logic [TO_WIDTH-1:0] TIMEOUT_CYCLES = TO_WIDTH'(DEFAULT_TIMEOUT_CYCLES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [I2C_ID_W*NUM_REQ-1:0]   req_id,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [I2C_DATA_W-1:0]         rdata,
    output logic                          busy,
    output logic                          IO_CONTROL_PULSE,
    output logic                          IO_CONTROL_RW,
    output logic [I2C_ID_W-1:0]           IO_CONTROL_ID,
    output logic [I2C_ADDR_W-1:0]         IO_ADDR_ADDR,
    output logic [I2C_DATA_W-1:0]         IO_WDATA_WDATA,
    input  logic [I2C_DATA_W-1:0]         IO_RDATA_RDATA,
    input  logic                          IO_CONTROL_CMPLT
);

    // state | meaning
    // IDLE  | no owner, waiting for any req
    // ISSUE | start pulse to sequencer, watchdog cleared
    // WAIT  | waiting for CMPLT or watchdog expiry
    // DONE  | done pulse to owner, rr pointer advances
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [TO_WIDTH-1:0] WD_LAST  = TIMEOUT_CYCLES - 1'b1;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]        idx_q, idx_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [TO_WIDTH-1:0]     wd_q, wd_d;
    logic                    rw_q, rw_d;
    logic [I2C_ID_W-1:0]     id_q, id_d;
    logic [I2C_ADDR_W-1:0]   addr_q, addr_d;
    logic [I2C_DATA_W-1:0]   wdata_q, wdata_d;
    logic [I2C_DATA_W-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      pick_grant;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_valid;

    logic [I2C_ID_W-1:0]     id_arr    [NUM_REQ];
    logic [I2C_ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [I2C_DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign id_arr[g]    = req_id[I2C_ID_W*g +: I2C_ID_W];
        assign addr_arr[g]  = req_addr[I2C_ADDR_W*g +: I2C_ADDR_W];
        assign wdata_arr[g] = req_wdata[I2C_DATA_W*g +: I2C_DATA_W];
    end

    qsfp_i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            rw_q    <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            rw_q    <= rw_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        rw_d    = rw_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                    rw_d    = req_rw[pick_idx];
                    id_d    = id_arr[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // CMPLT takes priority over a coincident watchdog expiry
                if (IO_CONTROL_CMPLT) begin
                    rdata_d = IO_RDATA_RDATA;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    rdata_d = TIMEOUT_RDATA;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                ptr_d   = (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant            = grant_q;
    assign done             = (state_q == ST_DONE) ? grant_q : '0;
    assign err              = err_q;
    assign rdata            = rdata_q;
    assign busy             = (state_q != ST_IDLE);
    assign IO_CONTROL_PULSE = (state_q == ST_ISSUE);
    assign IO_CONTROL_RW    = rw_q;
    assign IO_CONTROL_ID    = id_q;
    assign IO_ADDR_ADDR     = addr_q;
    assign IO_WDATA_WDATA   = wdata_q;

endmodule

// File: doc/qsfp_i2c_cmd_arbiter.md
Name: qsfp_i2c_cmd_arbiter

Overview:
- Shares the single I2C AXI sequencer command port (IO_CONTROL_* / IO_ADDR / IO_WDATA / IO_RDATA) between NUM_REQ requesters, e.g. the JTAG register block, the automated power-up state machine and a future monitor poller.
- Round-robin grant; one transaction outstanding at a time.
- Holds command fields stable until completion and returns read data to the granted requester.
- Watchdog timeout prevents a hung bus from locking out the other requesters.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 24'd3_000_000, max cycles in WAIT before abort (about 10 ms at 300 MHz).
- TO_WIDTH, 24, watchdog counter width.

Ports:
- clk  in  1  system clock (s_axi_aclk domain).
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester request level; held until its done pulse.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_id  in  8*NUM_REQ  I2C device/mux ID, requester i at [8i+7:8i].
- req_addr  in  8*NUM_REQ  register address.
- req_wdata  in  8*NUM_REQ  write data.
- grant  out  NUM_REQ  one-hot, current owner; 0 when idle.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- err  out  1  valid with done; 1 = timeout.
- rdata  out  8  read data, valid with done.
- busy  out  1  transaction in progress.
- IO_CONTROL_PULSE  out  1  one-cycle start to sequencer.
- IO_CONTROL_RW  out  1  registered command fields.
- IO_CONTROL_ID  out  8  registered command fields.
- IO_ADDR_ADDR  out  8  registered command fields.
- IO_WDATA_WDATA  out  8  registered command fields.
- IO_RDATA_RDATA  in  8  sequencer read data.
- IO_CONTROL_CMPLT  in  1  sequencer completion pulse.

Behaviour:
- Reset: all outputs 0. State IDLE, rr pointer 0, watchdog 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req, select the first set bit at or after the rr pointer (wrapping). Register grant and latch that requester's rw/id/addr/wdata onto the IO_* outputs, then go to ISSUE. With no req, stay in IDLE.
- ISSUE: IO_CONTROL_PULSE = 1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT:
  - On IO_CONTROL_CMPLT, capture IO_RDATA_RDATA into rdata, set err = 0, go to DONE.
  - Otherwise, once the watchdog reaches TIMEOUT_CYCLES-1, set rdata = 8'hFF, set err = 1, go to DONE.
  - CMPLT and timeout in the same cycle: CMPLT wins, err = 0.
- DONE: done[owner] = 1 for one cycle. Advance rr pointer to owner+1 (mod NUM_REQ). Clear grant; go to IDLE.
- rdata/err hold until the next DONE.
- Latency: req sampled in IDLE at cycle t, then grant at t+1 and PULSE at t+1 (ISSUE). If CMPLT arrives at cycle c, done is at c+1.
- Minimum back-to-back spacing is 4 cycles per transaction. The rr pointer guarantees no starvation; worst-case wait is NUM_REQ-1 transactions.
- busy = 1 in ISSUE, WAIT and DONE.
- IO_* command outputs stay stable from ISSUE through DONE.
- Requester deasserting req mid-transaction: transaction still completes and done still pulses. Requester must not change its fields while req is held.
- IO_CONTROL_CMPLT outside WAIT (stray or late after timeout): ignored.
- Read rdata for write transactions is don't-care but is still captured.
- Reset mid-transaction: FSM returns to IDLE immediately and no done is issued. The sequencer is not aborted; a late CMPLT is ignored per the previous rule.
- NUM_REQ = 1: degenerates to a pass-through with timeout; rr pointer stays 0.

Decomposition:
- Shared package qsfp_i2c_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - I2C_ID_W = 8, I2C_ADDR_W = 8, I2C_DATA_W = 8;
  - TIMEOUT_RDATA = 8'hFF;
  - default TIMEOUT_CYCLES.
- One sub-module, qsfp_i2c_rr_pick: combinational round-robin priority pick (req, pointer, NUM_REQ) -> one-hot grant and index.

Test Plan:
- Single write: req[0] with rw=0, id=8'hE0, addr=8'h03, wdata=8'h01; CMPLT 20 cycles after PULSE -> exactly one PULSE with those fields; done[0] one cycle after CMPLT; err = 0; grant[1] never set.
- Single read: req[1] with rw=1, id=8'hA0, addr=8'h00; IO_RDATA_RDATA=8'h18 at CMPLT -> done[1] with rdata=8'h18, err=0.
- Contention: req[0] and req[1] asserted together and held for 4 transactions -> grant order 0,1,0,1; each done on the matching index; no overlapping PULSEs.
- Timeout: TIMEOUT_CYCLES=100 and CMPLT withheld -> done pulses 101 cycles after PULSE with err=1, rdata=8'hFF. A late CMPLT is ignored and the next request proceeds normally.
- Reset during WAIT: rst asserted 5 cycles after PULSE -> all outputs 0 immediately; no done. After release, a new req gets a fresh PULSE.
- CMPLT coincident with the timeout cycle -> err=0 and rdata = IO_RDATA_RDATA.
